conv_fprop_mac_acc: RTL and testbench
=====================================

Name: conv_fprop_mac_acc

Overview:
- Accumulation stage directly downstream of the conv_fprop signed product multiplier. Consumes one signed DIN_W-bit product per accepted beat and sums KLEN products plus a bias into one convolution output pixel.
- Emits the sum saturated to OUT_W bits over a valid/ready handshake to the activation/store stage.
- One window per output pixel; a window is KLEN products (default 3x3 kernel = 9).

Parameters:
- DIN_W, 10, signed product width (matches multiplier dout).
- KLEN, 9, products per window; must be ≥1.
- ACC_W, 16, internal signed accumulator width; must be ≥ DIN_W + clog2(KLEN+1).
- OUT_W, 10, signed result width after saturation.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst  in  1  synchronous, active-high reset.
- prod_din  in  DIN_W  signed product from multiplier.
- prod_vld  in  1  prod_din valid.
- prod_rdy  out  1  stage can accept prod_din.
- bias  in  DIN_W  signed bias, sampled with first product of each window.
- res_dout  out  OUT_W  saturated signed window sum.
- res_vld  out  1  res_dout/res_sat valid.
- res_rdy  in  1  downstream accepts result.
- res_sat  out  1  result was clipped.

Behaviour:
- Reset (ap_rst=1 at a rising edge): state=ACC, cnt=0, acc=0, prod_rdy=1 after reset, res_vld=0, res_dout=0, res_sat=0. Reset mid-window discards the partial sum; no residue carries into the next window.
- States: ACC, DONE.
- ACC: prod_rdy=1, res_vld=0. Beat accepted when prod_vld=1.
  - First beat of a window (cnt=0): acc_next = sext(bias) + sext(prod_din).
  - Other beats: acc_next = acc + sext(prod_din).
  - cnt increments per accepted beat; idle cycles (prod_vld=0) leave acc/cnt unchanged.
- On the beat with cnt=KLEN-1: final sum S=acc_next (full ACC_W).
  - res_dout <= sat(S): S>2^(OUT_W-1)-1 gives max, S<-2^(OUT_W-1) gives min, otherwise S truncated to OUT_W.
  - res_sat <= 1 if clipped, else 0.
  - cnt <= 0, acc <= 0, state <= DONE.
- DONE: prod_rdy=0, res_vld=1, res_dout/res_sat held stable. When res_rdy=1, state <= ACC next edge. res_vld deasserts the following cycle; prod_rdy returns to 1 the same cycle.
- Latency: res_vld asserts the cycle after the last product is accepted.
- Throughput: KLEN+1 cycles per window with res_rdy tied high.
- KLEN=1: every accepted beat is both first and last (S = bias + product).
- res_rdy while in ACC is ignored. prod_vld while in DONE is not accepted; upstream holds data.
- Accumulator never wraps given the ACC_W constraint. Saturation is applied only at output.
- All outputs registered except prod_rdy, which decodes state only.

Test Plan:
- Bias 0, products 1,2,…,9 back-to-back, res_rdy=1 → res_vld one cycle after 9th beat, res_dout=45, res_sat=0; prod_rdy low exactly one cycle.
- Bias 0, nine products 511 → sum 4599, res_dout=511, res_sat=1; nine products −512 → res_dout=−512, res_sat=1.
- Bias −10, nine products of 1 with random prod_vld gaps → res_dout=−1, res_sat=0; acc unaffected by idle cycles.
- res_rdy=0 for 5 cycles after result → res_vld, res_dout stay constant, prod_rdy=0 and prod_vld ignored; res_rdy=1 → next window of nine 3s (bias 0) gives 27.
- Assert ap_rst after 4 products of 100, then nine products of 2 with bias 0 → res_dout=18, res_sat=0.
- Bias 500, products 10,1,0,…,0 → S=511, res_dout=511, res_sat=0; bias 500, products 12,0,…,0 → S=512, res_dout=511, res_sat=1.

Source files
------------

// File: rtl/conv_fprop_mac_acc.sv
// conv_fprop_mac_acc: sums KLEN signed products plus a bias per window and emits the OUT_W-saturated result
// Ports:
//   ap_clk, ap_rst       rising-edge clock, synchronous active-high reset
//   prod_din/vld/rdy     signed product stream from the multiplier
//   bias                 signed bias, taken with the first product of each window
//   res_dout/vld/rdy     saturated window sum to the activation/store stage
//   res_sat              result was clipped
module conv_fprop_mac_acc #(
    parameter int DIN_W = 10,
    parameter int KLEN  = 9,
    parameter int ACC_W = 16,
    parameter int OUT_W = 10
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic signed [DIN_W-1:0] prod_din,
    input  logic                    prod_vld,
    output logic                    prod_rdy,
    input  logic signed [DIN_W-1:0] bias,
    output logic signed [OUT_W-1:0] res_dout,
    output logic                    res_vld,
    input  logic                    res_rdy,
    output logic                    res_sat
);
    localparam int CNT_W = $clog2(KLEN + 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
    typedef enum logic {ACC, DONE} state_t;
    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic                    w_last;
    logic                    w_hi;
    logic                    w_lo;
    assign w_bias_ext = {{(ACC_W-DIN_W){bias[DIN_W-1]}}, bias};
    assign w_prod_ext = {{(ACC_W-DIN_W){prod_din[DIN_W-1]}}, prod_din};
    // the first beat of a window restarts from the bias instead of the running sum
    assign w_acc_next = ((r_cnt == '0) ? w_bias_ext : r_acc) + w_prod_ext;
    assign w_last     = r_cnt == CNT_W'(KLEN - 1);
    assign w_hi       = w_acc_next > MAXV;
    assign w_lo       = w_acc_next < MINV;
    assign prod_rdy   = r_state == ACC;
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= ACC;
            r_cnt    <= '0;
            r_acc    <= '0;
            res_vld  <= 1'b0;
            res_dout <= '0;
            res_sat  <= 1'b0;
        end else if (r_state == ACC) begin
            if (prod_vld) begin
                if (w_last) begin
                    res_dout <= w_hi ? MAXV[OUT_W-1:0] : w_lo ? MINV[OUT_W-1:0] : w_acc_next[OUT_W-1:0];
                    res_sat  <= w_hi | w_lo;
                    res_vld  <= 1'b1;
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_state  <= DONE;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else if (res_rdy) begin
            res_vld <= 1'b0;
            r_state <= ACC;
        end
    end
endmodule

// File: tb/tb_conv_fprop_mac_acc.sv
// tb_conv_fprop_mac_acc: directed scoreboard bench for the conv_fprop accumulation stage
module tb_conv_fprop_mac_acc;
    localparam int DIN_W = 10;
    localparam int KLEN  = 9;
    localparam int ACC_W = 16;
    localparam int OUT_W = 10;
    typedef struct {int dout; int sat;} exp_t;
    typedef int win_t [KLEN];
    logic                    ap_clk = 1'b0;
    logic                    ap_rst = 1'b1;
    logic signed [DIN_W-1:0] prod_din = '0;
    logic                    prod_vld = 1'b0;
    logic                    prod_rdy;
    logic signed [DIN_W-1:0] bias = '0;
    logic signed [OUT_W-1:0] res_dout;
    logic                    res_vld;
    logic                    res_rdy = 1'b1;
    logic                    res_sat;
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    always #5 ap_clk = ~ap_clk;
    conv_fprop_mac_acc #(.DIN_W(DIN_W), .KLEN(KLEN), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_din(prod_din), .prod_vld(prod_vld),
        .prod_rdy(prod_rdy), .bias(bias), .res_dout(res_dout), .res_vld(res_vld),
        .res_rdy(res_rdy), .res_sat(res_sat)
    );
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge ap_clk) begin
        exp_t e;
        if (!ap_rst && res_vld && res_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_result", int'(res_dout), -99999);
            end else begin
                e = q.pop_front();
                chk("res_dout", int'(res_dout), e.dout);
                chk("res_sat", int'(res_sat), e.sat);
            end
        end
    end
    task automatic beat(input int din);
        bit ok;
        ok = 1'b0;
        prod_vld = 1'b1;
        prod_din = DIN_W'(din);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge ap_clk);
            ok = prod_rdy;
            @(posedge ap_clk);
            #1;
        end
        if (!ok) chk("beat_timeout", 0, 1);
        prod_vld = 1'b0;
    endtask
    task automatic window(input int b, input win_t p, input bit gaps, input int ed, input int es);
        exp_t e;
        e.dout = ed;
        e.sat  = es;
        q.push_back(e);
        bias = DIN_W'(b);
        for (int i = 0; i < KLEN; i++) begin
            beat(p[i]);
            if (gaps && i < KLEN - 1) repeat ($urandom_range(0, 2)) begin
                @(posedge ap_clk);
                #1;
            end
        end
    endtask
    initial begin
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_vld", int'(res_vld), 0);
        chk("rst_rdy", int'(prod_rdy), 1);
        chk("rst_dout", int'(res_dout), 0);
        chk("rst_sat", int'(res_sat), 0);
        ap_rst = 1'b0;
        window(0, '{1, 2, 3, 4, 5, 6, 7, 8, 9}, 1'b0, 45, 0);
        chk("lat_vld", int'(res_vld), 1);
        chk("lat_rdy_low", int'(prod_rdy), 0);
        @(posedge ap_clk);
        #1;
        chk("rdy_back", int'(prod_rdy), 1);
        chk("vld_drop", int'(res_vld), 0);
        window(0, '{511, 511, 511, 511, 511, 511, 511, 511, 511}, 1'b0, 511, 1);
        window(0, '{-512, -512, -512, -512, -512, -512, -512, -512, -512}, 1'b0, -512, 1);
        window(-10, '{1, 1, 1, 1, 1, 1, 1, 1, 1}, 1'b1, -1, 0);
        @(posedge ap_clk);
        #1;
        res_rdy = 1'b0;
        window(0, '{5, 5, 5, 5, 5, 5, 5, 5, 5}, 1'b0, 45, 0);
        prod_vld = 1'b1;
        prod_din = DIN_W'(7);
        repeat (5) begin
            @(posedge ap_clk);
            #1;
            chk("hold_vld", int'(res_vld), 1);
            chk("hold_dout", int'(res_dout), 45);
            chk("hold_rdy", int'(prod_rdy), 0);
        end
        prod_vld = 1'b0;
        res_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        window(0, '{3, 3, 3, 3, 3, 3, 3, 3, 3}, 1'b0, 27, 0);
        @(posedge ap_clk);
        #1;
        bias = '0;
        repeat (4) beat(100);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("midrst_vld", int'(res_vld), 0);
        chk("midrst_rdy", int'(prod_rdy), 1);
        chk("midrst_dout", int'(res_dout), 0);
        chk("midrst_sat", int'(res_sat), 0);
        window(0, '{2, 2, 2, 2, 2, 2, 2, 2, 2}, 1'b0, 18, 0);
        window(500, '{10, 1, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 511, 0);
        window(500, '{12, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 511, 1);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
